// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one physical memory port between instruction fetch
// (port 0, read-only) and data (port 1, read/write); data has priority with starvation relief.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [15:0] i_address,
    output logic [15:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [15:0] d_address,
    input  logic [15:0] d_wdata,
    input  logic [1:0]  d_byte_enable,
    output logic [15:0] d_rdata,
    output logic        d_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_byte_enable,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp,
    output logic        busy
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_I  = 2'd1,
        BUSY_D  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t      state_r;
    logic [3:0]  starve_cnt_r;
    logic [15:0] addr_r;
    logic [15:0] wdata_r;
    logic [1:0]  be_r;
    logic        read_r;
    logic        write_r;
    logic        busy_r;
    logic [15:0] i_rdata_r;
    logic [15:0] d_rdata_r;
    logic        d_req_s;
    logic        grant_i_s;
    logic        grant_d_s;

    assign d_req_s = d_read | d_write;

    // Grant decision, evaluated only while idle; data wins unless fetch has waited too long
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (state_r == IDLE) begin
            if (d_req_s && i_read) begin
                if (starve_cnt_r < LIMIT_C) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_i_s = 1'b1;
                end
            end else if (d_req_s) begin
                grant_d_s = 1'b1;
            end else if (i_read) begin
                grant_i_s = 1'b1;
            end else begin
                grant_i_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // Completion must be visible in the same cycle as pmem_resp, so it is decoded from state
    assign i_resp  = (state_r == BUSY_I) & pmem_resp;
    assign d_resp  = (state_r == BUSY_D) & pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : i_rdata_r;
    assign d_rdata = d_resp ? pmem_rdata : d_rdata_r;

    assign pmem_read        = read_r;
    assign pmem_write       = write_r;
    assign pmem_address     = addr_r;
    assign pmem_wdata       = wdata_r;
    assign pmem_byte_enable = be_r;
    assign busy             = busy_r;

    // Arbiter FSM: latches the winning request and holds it until the memory completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            starve_cnt_r <= 4'd0;
            addr_r       <= 16'd0;
            wdata_r      <= 16'd0;
            be_r         <= 2'd0;
            read_r       <= 1'b0;
            write_r      <= 1'b0;
            busy_r       <= 1'b0;
            i_rdata_r    <= 16'd0;
            d_rdata_r    <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        addr_r  <= d_address;
                        wdata_r <= d_wdata;
                        be_r    <= d_byte_enable;
                        // read+write together is treated as a write
                        read_r  <= ~d_write;
                        write_r <= d_write;
                        busy_r  <= 1'b1;
                        state_r <= BUSY_D;
                        if (i_read && (starve_cnt_r < LIMIT_C)) begin
                            starve_cnt_r <= starve_cnt_r + 4'd1;
                        end
                    end else if (grant_i_s) begin
                        addr_r       <= i_address;
                        wdata_r      <= 16'd0;
                        be_r         <= 2'b11;
                        read_r       <= 1'b1;
                        write_r      <= 1'b0;
                        busy_r       <= 1'b1;
                        starve_cnt_r <= 4'd0;
                        state_r      <= BUSY_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (pmem_resp) begin
                        read_r  <= 1'b0;
                        write_r <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= RECOVER;
                        if (state_r == BUSY_I) begin
                            i_rdata_r <= pmem_rdata;
                        end else begin
                            d_rdata_r <= pmem_rdata;
                        end
                    end
                end
                RECOVER: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic checked
// by a scoreboard against a request-level arbitration model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read, d_read, d_write, pmem_resp;
    logic [15:0] i_address, d_address, d_wdata, pmem_rdata;
    logic [1:0]  d_byte_enable;
    logic [15:0] i_rdata, d_rdata, pmem_address, pmem_wdata;
    logic        i_resp, d_resp, pmem_read, pmem_write, busy;
    logic [1:0]  pmem_byte_enable;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .busy(busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit sb_on      = 1'b0;

    typedef struct packed {
        logic        wr;
        logic        port;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } txn_t;

    txn_t        pmem_q[$];
    logic        grant_port_q[$];
    logic [15:0] i_exp_q[$];
    logic [15:0] d_exp_q[$];
    int          m_cnt     = 0;
    bit          m_busy    = 1'b0;
    int          m_next_ok = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, {27'd0, pmem_read, pmem_write, i_resp, d_resp, busy}, 32'd0);
        check({name, "_be"}, {30'd0, pmem_byte_enable}, 32'd0);
        check({name, "_addr"}, {16'd0, pmem_address}, 32'd0);
        check({name, "_wdata"}, {16'd0, pmem_wdata}, 32'd0);
        check({name, "_rdata"}, {i_rdata, d_rdata}, 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: decides each grant from the request levels seen in an idle slot
    initial forever begin
        @(negedge clk);
        if (sb_on) begin
            if (m_busy && pmem_resp) begin
                m_busy    = 1'b0;
                m_next_ok = cyc + 2;
            end else if (!m_busy && cyc >= m_next_ok && (i_read || d_read || d_write)) begin
                txn_t t;
                logic take_d;
                take_d = (d_read || d_write) && !(i_read && m_cnt >= 4);
                if (take_d) begin
                    t = '{wr: d_write, port: 1'b1, addr: d_address, wdata: d_wdata, be: d_byte_enable};
                    if (i_read) m_cnt = (m_cnt < 4) ? m_cnt + 1 : m_cnt;
                end else begin
                    t = '{wr: 1'b0, port: 1'b0, addr: i_address, wdata: 16'd0, be: 2'b11};
                    m_cnt = 0;
                end
                pmem_q.push_back(t);
                grant_port_q.push_back(t.port);
                m_busy = 1'b1;
            end
        end
    end

    // Physical memory: random 0..3 cycle latency and random read data
    initial begin
        int dly = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_on) begin
                pmem_resp = 1'b0;
                if (pmem_read || pmem_write) begin
                    if (dly == 0) begin
                        pmem_resp  = 1'b1;
                        pmem_rdata = 16'($urandom);
                        if (grant_port_q.size() == 0) begin
                            check("resp_without_grant", 32'd1, 32'd0);
                        end else if (grant_port_q.pop_front()) begin
                            d_exp_q.push_back(pmem_rdata);
                        end else begin
                            i_exp_q.push_back(pmem_rdata);
                        end
                        dly = $urandom_range(0, 3);
                    end else begin
                        dly--;
                    end
                end
            end
        end
    end

    // Monitor: compares each physical transaction and each port completion with the scoreboard
    initial begin
        logic prev = 1'b0;
        txn_t cur = '0;
        forever begin
            @(negedge clk);
            if (sb_on) begin
                if ((pmem_read || pmem_write) && !prev) begin
                    if (pmem_q.size() == 0) begin
                        check("unexpected_txn", 32'd1, 32'd0);
                    end else begin
                        cur = pmem_q.pop_front();
                        check("txn_op", {30'd0, pmem_write, pmem_read}, {30'd0, cur.wr, ~cur.wr});
                        check("txn_be", {30'd0, pmem_byte_enable}, {30'd0, cur.be});
                        check("txn_wdata", {16'd0, pmem_wdata}, {16'd0, cur.wdata});
                    end
                end
                if (pmem_read || pmem_write) check("txn_addr", {16'd0, pmem_address}, {16'd0, cur.addr});
                prev = pmem_read || pmem_write;
                if (i_resp && d_resp) check("both_resp", 32'd1, 32'd0);
                if (i_resp) begin
                    if (i_exp_q.size() == 0) check("i_resp_unexpected", 32'd1, 32'd0);
                    else check("i_rdata", {16'd0, i_rdata}, {16'd0, i_exp_q.pop_front()});
                end
                if (d_resp) begin
                    if (d_exp_q.size() == 0) check("d_resp_unexpected", 32'd1, 32'd0);
                    else check("d_rdata", {16'd0, d_rdata}, {16'd0, d_exp_q.pop_front()});
                end
            end
        end
    end

    task automatic fetch_driver(input int n);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            @(posedge clk);
            #1;
            i_read    = 1'b1;
            i_address = 16'($urandom);
            do begin
                @(negedge clk);
                t++;
                if (busy && !i_resp && ($urandom_range(0, 1) == 1)) begin
                    #2 i_address = 16'($urandom);
                end
            end while (!i_resp && t < 400);
            if (!i_resp) check("fetch_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1;
            i_read = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic data_driver(input int n);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            int op = $urandom_range(0, 2);
            d_read        = (op != 1);
            d_write       = (op != 0);
            d_address     = 16'($urandom);
            d_wdata       = 16'($urandom);
            d_byte_enable = 2'($urandom);
            do begin
                @(negedge clk);
                t++;
                if (busy && !d_resp && ($urandom_range(0, 1) == 1)) begin
                    #2;
                    d_address = 16'($urandom);
                    d_wdata   = 16'($urandom);
                end
            end while (!d_resp && t < 400);
            if (!d_resp) check("data_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) begin
                d_read  = 1'b0;
                d_write = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    initial begin
        int last = 0;
        int ecnt = 0;
        int t;
        logic exp_i;
        rst = 1'b1;
        {i_read, d_read, d_write, pmem_resp} = 4'd0;
        {i_address, d_address, d_wdata, pmem_rdata} = 64'd0;
        d_byte_enable = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Single fetch with a 3-cycle memory and an address change mid-transaction
        @(posedge clk); #1;
        i_read = 1'b1; i_address = 16'h0040;
        @(posedge clk); #1;
        i_address = 16'h0080;
        for (int c = 0; c < 3; c++) begin
            check("fetch_strobe", {29'd0, pmem_read, pmem_write, busy}, 32'b101);
            check("fetch_addr", {16'd0, pmem_address}, 32'h0040);
            if (c == 2) begin
                pmem_resp = 1'b1; pmem_rdata = 16'h1234;
                #1;
                check("fetch_resp", {30'd0, i_resp, d_resp}, 32'b10);
                check("fetch_rdata", {16'd0, i_rdata}, 32'h1234);
            end
            @(posedge clk); #1;
        end
        i_read = 1'b0; pmem_rdata = 16'hFFFF;
        #1;
        check("recover_ignores_resp", {28'd0, pmem_read, pmem_write, i_resp, d_resp}, 32'd0);
        check("fetch_rdata_held", {16'd0, i_rdata}, 32'h1234);
        pmem_resp = 1'b0;
        @(posedge clk); #1;

        // Data write
        d_write = 1'b1; d_address = 16'h0101; d_wdata = 16'hABAB; d_byte_enable = 2'b10;
        @(posedge clk); #1;
        d_wdata = 16'h0000;
        check("write_strobe", {30'd0, pmem_write, pmem_read}, 32'b10);
        check("write_latch", {pmem_address, pmem_wdata}, 32'h0101ABAB);
        check("write_be", {30'd0, pmem_byte_enable}, 32'b10);
        pmem_resp = 1'b1; pmem_rdata = 16'h5555;
        #1;
        check("write_resp", {30'd0, i_resp, d_resp}, 32'b01);
        @(posedge clk); #1;
        d_write = 1'b0; pmem_resp = 1'b0;
        check("write_recover", {29'd0, pmem_read, pmem_write, busy}, 32'd0);
        @(posedge clk); #1;

        // Contention with both requests held: D,D,D,D,I,D and 3-cycle grant spacing
        i_read = 1'b1; i_address = 16'hF000;
        d_read = 1'b1; d_address = 16'h0D00;
        for (int g = 0; g < 6; g++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!(pmem_read || pmem_write) && t < 20);
            exp_i = (ecnt == 4);
            ecnt  = exp_i ? 0 : ecnt + 1;
            check("starve_port", {31'd0, (pmem_address == 16'hF000)}, {31'd0, exp_i});
            check("starve_cnt", {28'd0, dut.starve_cnt_r}, 32'(ecnt));
            if (g > 0) check("grant_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            pmem_resp = 1'b1; pmem_rdata = 16'(16'h0A00 + g);
            #1;
            check("starve_resp", {30'd0, i_resp, d_resp}, exp_i ? 32'b10 : 32'b01);
            check("starve_rdata", {16'd0, (exp_i ? i_rdata : d_rdata)}, 32'(16'h0A00 + g));
            @(posedge clk); #1;
            pmem_resp = 1'b0;
        end
        i_read = 1'b0; d_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during a data transaction with pmem_resp pending
        d_read = 1'b1; d_address = 16'h0222;
        @(posedge clk); #1;
        check("busy_d", {31'd0, busy}, 32'd1);
        pmem_resp = 1'b1; pmem_rdata = 16'h0077;
        #1;
        check("pre_rst_resp", {30'd0, i_resp, d_resp}, 32'b01);
        rst = 1'b1; d_read = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("post_rst_noresp", {29'd0, i_resp, d_resp, pmem_read}, 32'd0);
        end
        check("post_rst_cnt", {28'd0, dut.starve_cnt_r}, 32'd0);
        pmem_resp = 1'b0;

        // Randomized traffic against the scoreboard
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_cnt = 0; m_busy = 1'b0; m_next_ok = 0;
        sb_on = 1'b1;
        fork
            fetch_driver(40);
            data_driver(80);
        join
        repeat (10) @(posedge clk);
        #1;
        sb_on = 1'b0;
        check("pmem_q_empty", 32'(pmem_q.size()), 32'd0);
        check("exp_q_empty", 32'(i_exp_q.size() + d_exp_q.size()), 32'd0);
        check("final_cnt", {28'd0, dut.starve_cnt_r}, 32'(m_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
